program_loader_controller: RTL and testbench
============================================

# program_loader_controller

Hardware program loader and run supervisor for `single_cycle_BRAM_top`-style cores. It accepts a stream of program words and writes them into the core's byte-enabled program BRAM through a write port, holding the core in reset while loading. It then releases the core with a one-cycle `start` pulse at a chosen `program_address`, counts cycles until the PC reaches a halt address or a timeout expires, and reports the result after a drain period. The block is the hardware initiator for the core's `reset`/`start`/`program_address`/`PC` interface, taking over the job the simulation benches do with backdoor loads.

## Interface
- DATA_WIDTH, 32, program word width; a multiple of 8.
- ADDRESS_BITS, 32, PC and `program_address` width.
- MEM_ADDRESS_BITS, 14, BRAM word-address width; capacity is 2**MEM_ADDRESS_BITS words.
- HALT_PC_0, 32'h000000a8, first halt address.
- HALT_PC_1, 32'h000000ac, second halt address.
- MAX_CYCLES, 1000000, run-cycle timeout; must be ≥ 2.
- DRAIN_CYCLES, 50, cycles to wait after halt or timeout before `done`.
- CYCLE_BITS, 32, width of `cycle_count`.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  program word available.
- load_ready  out  1  loader accepts a word this cycle.
- load_data  in  DATA_WIDTH  program word.
- load_last  in  1  marks the final word of the program.
- run_address  in  ADDRESS_BITS  entry PC, sampled in RELEASE.
- restart  in  1  in DONE, begin a new load.
- abort  in  1  synchronous; from RELEASE, RUN or DRAIN, return to LOAD.
- mem_write  out  1  BRAM write strobe.
- mem_byte_en  out  DATA_WIDTH/8  byte enables.
- mem_address  out  MEM_ADDRESS_BITS  BRAM word address.
- mem_data  out  DATA_WIDTH  BRAM write data.
- core_reset  out  1  active-high reset to the core.
- start  out  1  one-cycle start pulse to the core.
- program_address  out  ADDRESS_BITS  start PC to the core.
- PC  in  ADDRESS_BITS  current core PC.
- done  out  1  result valid.
- status  out  2  result code: 00 none, 01 halted, 10 timeout, 11 overflow-halted (program truncated, then halted normally).
- overflow  out  1  more words were offered than the memory holds.
- cycle_count  out  CYCLE_BITS  run cycles.

## Operation
- States: LOAD, RELEASE, RUN, DRAIN, DONE. Reset enters LOAD.
- All outputs are registered. Values while reset is asserted:
  - `core_reset` = 1.
  - `load_ready`, `mem_write`, `start`, `done`, `overflow` = 0.
  - `status` = 00; `cycle_count` = 0.
  - `mem_address`, `mem_data`, `program_address` = 0.
  - `mem_byte_en` = all ones.
- LOAD:
  - `core_reset` = 1 and `load_ready` = 1.
  - A handshake (valid & ready) writes `load_data` to the word pointer on the next cycle: `mem_write` = 1, `mem_byte_en` = all ones. The pointer then increments.
  - The pointer starts at 0 on each entry to LOAD.
  - If a handshake has `load_last` = 1, or the pointer reaches 2**MEM_ADDRESS_BITS-1 with `load_last` = 0, go to RELEASE and drop `load_ready`.
  - In the pointer-full case without `load_last`, set `overflow` = 1. Further words are not accepted.
- RELEASE (one cycle):
  - `core_reset` = 0, `start` = 1, `program_address` = `run_address`, `cycle_count` = 0.
  - Then go to RUN.
- RUN:
  - `cycle_count` increments every cycle; the first RUN cycle shows 1.
  - If `PC` equals HALT_PC_0 or HALT_PC_1: freeze `cycle_count`, set `status` = 01 (11 if `overflow`), go to DRAIN.
  - Else if `cycle_count` = MAX_CYCLES-1: freeze `cycle_count` at MAX_CYCLES, set `status` = 10, go to DRAIN.
  - If halt and timeout occur in the same cycle, halt wins.
- DRAIN:
  - The core keeps running (`core_reset` = 0) for DRAIN_CYCLES cycles.
  - `status` and `cycle_count` are held; then go to DONE.
- DONE:
  - `done` = 1; `core_reset` stays 0 so the core's register file stays intact.
  - `restart` = 1 goes to LOAD: `core_reset` = 1, `done` = 0, `status` = 00, `overflow` = 0.
- `abort` in RELEASE, RUN or DRAIN goes to LOAD the next cycle with `core_reset` = 1, `status` = 00 and `done` = 0. `abort` is ignored in LOAD and DONE.
- Asynchronous reset mid-load leaves already-written BRAM contents untouched. Only the pointer and state are cleared.
- `cycle_count` saturates at its maximum value and never wraps.

## Timing
- The first `load_ready` = 1 is the first rising edge after reset deasserts.
- Write latency is one cycle: a handshake at edge N gives `mem_write` high during cycle N+1. Throughput is one word per cycle.
- The `load_last` handshake at edge N puts the final write in cycle N+1 and RELEASE in cycle N+1. The core leaves reset in the same cycle as the last write, which is safe because the core's first fetch comes the next edge.
- `start` is high for exactly one cycle, coincident with the first cycle of `core_reset` = 0.
- PC compare is registered: halt detected from PC at edge N gives the state change at edge N+1.
- `done` rises exactly DRAIN_CYCLES+1 cycles after the halt-detect edge.

## Test plan
- Load 4 words (0x00000013 ×3, then `load_last`) → `mem_write` at addresses 0..3 in 4 consecutive cycles with `mem_byte_en` = 4'hF. Then RELEASE: `start` = 1 for one cycle with `core_reset` = 0.
- Let `PC` reach 0x000000a8 in the 21st RUN cycle → `cycle_count` = 21, `status` = 01. `done` rises DRAIN_CYCLES+1 cycles later; no further writes occur.
- Use MAX_CYCLES = 8 and never hit a halt PC → `status` = 10, `cycle_count` = 8, `done` = 1.
- Use MEM_ADDRESS_BITS = 2 and offer 6 words without `load_last` → 4 writes at addresses 0..3, `overflow` = 1, `load_ready` = 0 after the 4th word. Reaching HALT_PC gives `status` = 11.
- Assert `abort` in RUN cycle 5 → the next cycle shows `core_reset` = 1, `load_ready` = 1, `status` = 00. The reload then starts at address 0.
- Assert async reset mid-load after 3 words → outputs take their reset values immediately. After release, the pointer restarts at 0.

Source files
------------

// File: rtl/program_loader_controller.sv
// Program loader and run supervisor: streams words into the core's program BRAM,
// releases the core with a start pulse, then watches PC for halt or timeout.
module program_loader_controller #(
  parameter int                      DATA_WIDTH       = 32,
  parameter int                      ADDRESS_BITS     = 32,
  parameter int                      MEM_ADDRESS_BITS = 14,
  parameter logic [ADDRESS_BITS-1:0] HALT_PC_0        = 32'h000000a8,
  parameter logic [ADDRESS_BITS-1:0] HALT_PC_1        = 32'h000000ac,
  parameter int                      MAX_CYCLES       = 1000000,
  parameter int                      DRAIN_CYCLES     = 50,
  parameter int                      CYCLE_BITS       = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [DATA_WIDTH-1:0]       load_data,
  input  logic                        load_last,
  input  logic [ADDRESS_BITS-1:0]     run_address,
  input  logic                        restart,
  input  logic                        abort,
  output logic                        mem_write,
  output logic [DATA_WIDTH/8-1:0]     mem_byte_en,
  output logic [MEM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        core_reset,
  output logic                        start,
  output logic [ADDRESS_BITS-1:0]     program_address,
  input  logic [ADDRESS_BITS-1:0]     PC,
  output logic                        done,
  output logic [1:0]                  status,
  output logic                        overflow,
  output logic [CYCLE_BITS-1:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_RELEASE = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int                    BE_W      = DATA_WIDTH / 8;
  localparam logic [CYCLE_BITS-1:0] CNT_LAST  = CYCLE_BITS'(MAX_CYCLES - 1);
  localparam logic [CYCLE_BITS-1:0] CNT_TMO   = CYCLE_BITS'(MAX_CYCLES);
  localparam logic [CYCLE_BITS-1:0] CNT_SAT   = {CYCLE_BITS{1'b1}};
  localparam logic [31:0]           DRAIN_END = 32'(DRAIN_CYCLES - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic [MEM_ADDRESS_BITS-1:0] r_ptr;
  logic                        r_hit;
  logic [31:0]                 r_drain;
  logic                        w_pc_hit;
  logic                        w_fire;
  logic                        w_ptr_full;

  // Next-state logic; r_hit carries the registered halt compare into the transition.
  always_comb begin
    w_next     = r_state;
    w_pc_hit   = (PC == HALT_PC_0) || (PC == HALT_PC_1);
    w_fire     = load_valid && load_ready && (r_state == S_LOAD);
    w_ptr_full = &r_ptr;
    case (r_state)
      S_LOAD: begin
        if (w_fire && (load_last || w_ptr_full)) w_next = S_RELEASE;
        else                                     w_next = S_LOAD;
      end
      S_RELEASE: begin
        if (abort) w_next = S_LOAD;
        else       w_next = S_RUN;
      end
      S_RUN: begin
        if (abort)                                    w_next = S_LOAD;
        else if (r_hit)                               w_next = S_DRAIN;
        else if (!w_pc_hit && cycle_count == CNT_LAST) w_next = S_DRAIN;
        else                                          w_next = S_RUN;
      end
      S_DRAIN: begin
        if (abort)                  w_next = S_LOAD;
        else if (r_drain == DRAIN_END) w_next = S_DONE;
        else                        w_next = S_DRAIN;
      end
      S_DONE: begin
        if (restart) w_next = S_LOAD;
        else         w_next = S_DONE;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Registered outputs, derived from the state being entered so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_reset      <= 1'b1;
      load_ready      <= 1'b0;
      mem_write       <= 1'b0;
      start           <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      status          <= 2'b00;
      cycle_count     <= {CYCLE_BITS{1'b0}};
      mem_address     <= {MEM_ADDRESS_BITS{1'b0}};
      mem_data        <= {DATA_WIDTH{1'b0}};
      program_address <= {ADDRESS_BITS{1'b0}};
      mem_byte_en     <= {BE_W{1'b1}};
      r_ptr           <= {MEM_ADDRESS_BITS{1'b0}};
      r_hit           <= 1'b0;
      r_drain         <= 32'd0;
    end else begin
      core_reset  <= (w_next == S_LOAD);
      load_ready  <= (w_next == S_LOAD);
      start       <= (w_next == S_RELEASE);
      done        <= (w_next == S_DONE);
      mem_byte_en <= {BE_W{1'b1}};
      mem_write   <= w_fire;
      if (w_fire) begin
        mem_address <= r_ptr;
        mem_data    <= load_data;
      end
      if (r_state != S_LOAD) r_ptr <= {MEM_ADDRESS_BITS{1'b0}};
      else if (w_fire)       r_ptr <= r_ptr + MEM_ADDRESS_BITS'(1);
      r_hit   <= (r_state == S_RUN) && (w_next == S_RUN) && (r_hit || w_pc_hit);
      r_drain <= (r_state == S_DRAIN) ? r_drain + 32'd1 : 32'd0;
      // A fresh load (restart or abort) clears the previous result.
      if ((w_next == S_LOAD) && (r_state != S_LOAD)) begin
        status   <= 2'b00;
        overflow <= 1'b0;
      end else if (w_fire && w_ptr_full && !load_last) begin
        overflow <= 1'b1;
      end
      case (r_state)
        S_LOAD: begin
          if (w_next == S_RELEASE) begin
            program_address <= run_address;
            cycle_count     <= {CYCLE_BITS{1'b0}};
          end
        end
        S_RELEASE: begin
          if (w_next == S_RUN) cycle_count <= CYCLE_BITS'(1);
        end
        S_RUN: begin
          if (w_next == S_RUN) begin
            // Count freezes on the cycle the halt PC is seen.
            if (!r_hit && !w_pc_hit && cycle_count != CNT_SAT)
              cycle_count <= cycle_count + CYCLE_BITS'(1);
          end else if (w_next == S_DRAIN) begin
            if (r_hit) begin
              status <= overflow ? 2'b11 : 2'b01;
            end else begin
              status      <= 2'b10;
              cycle_count <= CNT_TMO;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader_controller.sv
// Directed bench: instance A (4-word memory) covers load, halt, overflow, abort and
// async reset; instance B (MAX_CYCLES = 8) shares the stimulus and covers timeout.
module tb_program_loader_controller;

  logic        clock, reset, load_valid, load_last, restart, abort;
  logic [31:0] load_data, run_address, a_pc, b_pc;

  logic        a_load_ready, a_mem_write, a_core_reset, a_start, a_done, a_overflow;
  logic [3:0]  a_mem_byte_en;
  logic [1:0]  a_mem_address, a_status;
  logic [31:0] a_mem_data, a_program_address, a_cycle_count;

  logic        b_load_ready, b_mem_write, b_core_reset, b_start, b_done, b_overflow;
  logic [3:0]  b_mem_byte_en, b_mem_address;
  logic [1:0]  b_status;
  logic [31:0] b_mem_data, b_program_address, b_cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  int a_wr_cnt = 0;

  program_loader_controller #(.MEM_ADDRESS_BITS(2), .DRAIN_CYCLES(6)) u_dut_a (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(a_load_ready),
    .load_data(load_data), .load_last(load_last), .run_address(run_address),
    .restart(restart), .abort(abort), .mem_write(a_mem_write), .mem_byte_en(a_mem_byte_en),
    .mem_address(a_mem_address), .mem_data(a_mem_data), .core_reset(a_core_reset),
    .start(a_start), .program_address(a_program_address), .PC(a_pc), .done(a_done),
    .status(a_status), .overflow(a_overflow), .cycle_count(a_cycle_count)
  );

  program_loader_controller #(.MEM_ADDRESS_BITS(4), .MAX_CYCLES(8), .DRAIN_CYCLES(6)) u_dut_b (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(b_load_ready),
    .load_data(load_data), .load_last(load_last), .run_address(run_address),
    .restart(restart), .abort(abort), .mem_write(b_mem_write), .mem_byte_en(b_mem_byte_en),
    .mem_address(b_mem_address), .mem_data(b_mem_data), .core_reset(b_core_reset),
    .start(b_start), .program_address(b_program_address), .PC(b_pc), .done(b_done),
    .status(b_status), .overflow(b_overflow), .cycle_count(b_cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (a_mem_write) a_wr_cnt <= a_wr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_done(input int bound);
    int k;
    k = 0;
    while (!a_done && k < bound) begin
      @(negedge clock);
      k++;
    end
    check_val("wait_done", {63'd0, a_done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d;
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
    restart = 1'b0; abort = 1'b0; run_address = 32'h00000040;
    a_pc = 32'h0; b_pc = 32'h0;

    repeat (2) @(negedge clock);
    check_val("rst_ctrl", {a_core_reset, a_load_ready, a_mem_write, a_start, a_done, a_overflow}, 64'b100000);
    check_val("rst_status_cnt", {a_status, a_cycle_count}, 64'd0);
    check_val("rst_mem", {a_mem_byte_en, a_mem_address, a_mem_data}, {4'hF, 2'b00, 32'h0});
    check_val("rst_prog_addr", a_program_address, 64'd0);
    reset = 1'b1;

    @(negedge clock);
    check_val("first_ready", {a_load_ready, a_core_reset, a_mem_write}, 64'b110);
    load_valid = 1'b1; load_data = 32'h00000013;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp_d = (i == 3) ? 32'h00100073 : 32'h00000013;
      check_val($sformatf("load_wr%0d", i), {a_mem_write, a_mem_byte_en, a_mem_address, a_mem_data},
                {1'b1, 4'hF, 2'(i), exp_d});
      if (i == 2) begin
        load_last = 1'b1; load_data = 32'h00100073;
      end
      if (i == 3) begin
        load_valid = 1'b0; load_last = 1'b0;
      end
    end
    check_val("release", {a_start, a_core_reset, a_load_ready, a_cycle_count}, {3'b100, 32'd0});
    check_val("release_pc", a_program_address, 64'h40);

    @(negedge clock);
    check_val("run1", {a_start, a_core_reset, a_cycle_count}, {2'b00, 32'd1});
    repeat (20) @(negedge clock);
    check_val("run21", a_cycle_count, 64'd21);
    a_pc = 32'h000000a8;
    @(negedge clock);
    check_val("halt_freeze", {a_status, a_cycle_count}, {2'b00, 32'd21});
    a_pc = 32'h000000b0;
    @(negedge clock);
    check_val("halt_status", {a_done, a_status, a_cycle_count}, {1'b0, 2'b01, 32'd21});
    repeat (5) @(negedge clock);
    check_val("drain_not_done", {63'd0, a_done}, 64'd0);
    @(negedge clock);
    check_val("halt_done", {a_done, a_core_reset, a_status, a_cycle_count}, {2'b10, 2'b01, 32'd21});
    check_val("write_total", a_wr_cnt, 64'd4);
    check_val("timeout_done", {b_done, b_status, b_cycle_count}, {1'b1, 2'b10, 32'd8});

    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check_val("restart_a", {a_core_reset, a_load_ready, a_done, a_status, a_overflow}, 64'b110000);
    check_val("restart_b", {b_core_reset, b_load_ready, b_done, b_status, b_overflow}, 64'b110000);

    load_valid = 1'b1; load_data = 32'h000000a0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val($sformatf("ovf_wr%0d", i), {a_mem_write, a_mem_address, a_mem_data},
                {1'b1, 2'(i), 32'h000000a0 + 32'(i)});
      load_data = 32'h000000a1 + 32'(i);
    end
    check_val("ovf_flag", {a_overflow, a_load_ready, a_start}, 64'b101);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_val($sformatf("ovf_no_write%0d", i), {a_mem_write, a_load_ready}, 64'd0);
    end
    load_valid = 1'b0;
    a_pc = 32'h000000ac;
    @(negedge clock);
    a_pc = 32'h0;
    @(negedge clock);
    check_val("ovf_halt", {a_status, a_overflow, a_cycle_count}, {2'b11, 1'b1, 32'd2});
    wait_a_done(20);

    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    load_valid = 1'b1; load_data = 32'h00000011;
    @(negedge clock);
    check_val("ab_wr0", {a_mem_write, a_mem_address}, 64'b100);
    load_data = 32'h00000022; load_last = 1'b1;
    @(negedge clock);
    check_val("ab_wr1", {a_start, a_mem_write, a_mem_address}, 64'b1101);
    load_valid = 1'b0; load_last = 1'b0;
    repeat (5) @(negedge clock);
    check_val("ab_run5", a_cycle_count, 64'd5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_val("abort_load", {a_core_reset, a_load_ready, a_status, a_done, a_start}, 64'b110000);

    load_valid = 1'b1; load_data = 32'h00000033;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val($sformatf("reload_wr%0d", i), {a_mem_write, a_mem_address, a_mem_data},
                {1'b1, 2'(i), 32'h00000033 + 32'h11 * 32'(i)});
      load_data = 32'h00000044 + 32'h11 * 32'(i);
    end

    #2 reset = 1'b0;
    #1;
    check_val("async_rst_ctrl", {a_core_reset, a_load_ready, a_mem_write, a_start, a_done}, 64'b10000);
    check_val("async_rst_mem", {a_mem_address, a_mem_data}, 64'd0);
    @(negedge clock);
    reset = 1'b1; load_data = 32'h00000077;
    @(negedge clock);
    check_val("post_rst_ready", {a_load_ready, a_mem_write}, 64'b10);
    @(negedge clock);
    check_val("post_rst_wr0", {a_mem_write, a_mem_address, a_mem_data}, {1'b1, 2'b00, 32'h77});
    load_valid = 1'b0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
